// File: rtl/binary_up_counter.sv
// Free-running binary up-counter with asynchronous active-low reset.
// Counts RESET_VAL..MAX_COUNT and wraps back to RESET_VAL.
module binary_up_counter #(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0,
   parameter int MAX_COUNT = (2**WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] cnt
);

   if (WIDTH < 1) begin : g_bad_width
      $error("binary_up_counter: WIDTH must be at least 1");
   end
   if (MAX_COUNT > (2**WIDTH) - 1) begin : g_bad_max
      $error("binary_up_counter: MAX_COUNT does not fit in WIDTH bits");
   end
   if (RESET_VAL > MAX_COUNT) begin : g_bad_reset
      $error("binary_up_counter: RESET_VAL exceeds MAX_COUNT");
   end

   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Increment stays at WIDTH bits; carry out of the top bit is dropped.
   always_comb begin
      cnt_d = cnt_q + WIDTH'(1);
      if (cnt_q == MAX_V) begin
         cnt_d = RESET_V;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RESET_V;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: tb/tb_binary_up_counter.sv
// Bench for binary_up_counter: default 4-bit instance plus a WIDTH=3, MAX_COUNT=5 instance,
// checked every cycle against a modulo-arithmetic model and a few literal expectations.
module tb_binary_up_counter;

   logic       clk;
   logic       rst_n;
   logic [3:0] cnt;
   logic [2:0] cnt3;

   int checks;
   int errors;

   int  model_cnt;
   int  model_cnt3;
   bit  model_valid;

   binary_up_counter u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt)
   );

   binary_up_counter #(
      .WIDTH     (3),
      .RESET_VAL (0),
      .MAX_COUNT (5)
   ) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
      end
   endtask

   // Reference: reset value 0, counts modulo (MAX_COUNT+1).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_cnt   = 0;
         model_cnt3  = 0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         model_cnt  = (model_cnt + 1) % 16;
         model_cnt3 = (model_cnt3 + 1) % 6;
      end
   end

   always @(posedge clk) begin
      #1;
      if (model_valid) begin
         check("model_cnt4", {28'd0, cnt}, model_cnt);
         check("model_cnt3", {29'd0, cnt3}, model_cnt3);
      end
   end

   int seq3 [6] = '{1, 2, 3, 4, 5, 0};

   initial begin
      checks      = 0;
      errors      = 0;
      model_cnt   = 0;
      model_cnt3  = 0;
      model_valid = 1'b0;
      rst_n       = 1'b1;

      // Async reset assert between clock edges.
      #10 rst_n = 1'b0;
      #1;
      check("reset_async_cnt4", {28'd0, cnt}, 0);
      check("reset_async_cnt3", {29'd0, cnt3}, 0);
      #9 rst_n = 1'b1;

      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 1)  check("release_first", {28'd0, cnt}, 1);
         if (i == 15) check("reach_max", {28'd0, cnt}, 15);
         if (i == 16) check("wrap_to_zero", {28'd0, cnt}, 0);
         if (i == 17) check("after_wrap", {28'd0, cnt}, 1);
         if (i == 20) check("final_after_20", {28'd0, cnt}, 4);
         if (i <= 6)  check("small_seq", {29'd0, cnt3}, seq3[i-1]);
         if (i > 6)   check("small_in_range", {31'd0, (cnt3 <= 3'd5)}, 1);
      end

      // Reset mid-count at cnt=4, held across one edge.
      #4 rst_n = 1'b0;
      #1;
      check("midcount_reset", {28'd0, cnt}, 0);
      @(posedge clk);
      #1;
      check("midcount_hold", {28'd0, cnt}, 0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midcount_release", {28'd0, cnt}, 1);
      check("midcount_release3", {29'd0, cnt3}, 1);

      // Reset held low across three edges.
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("long_reset_hold", {28'd0, cnt}, 0);
         check("long_reset_hold3", {29'd0, cnt3}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("long_release_1", {28'd0, cnt}, 1);
      @(posedge clk);
      #1;
      check("long_release_2", {28'd0, cnt}, 2);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
